// File: rtl/axi4_stream_to_axi4.sv
// Write-side DMA stage: stores one AXI4-Stream packet per strobe
// to memory as AXI4 INCR bursts of at most 256 beats.
module axi4_stream_to_axi4 #(
    parameter int DATA_WIDTH         = 64,
    parameter int DATA_WIDTH_B       = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH         = 32,
    parameter int ID_WIDTH           = 1,
    parameter int AWUSER_WIDTH       = 1,
    parameter int WUSER_WIDTH        = 1,
    parameter int ARUSER_WIDTH       = 1,
    parameter int MAX_PKT_SIZE_B     = 2048,
    parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic                          wr_stb_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [MAX_PKT_SIZE_WIDTH:0]   pkt_size_o,
    output logic                          err_o,
    input  logic [DATA_WIDTH-1:0]         pkt_tdata,
    input  logic [DATA_WIDTH_B-1:0]       pkt_tkeep,
    input  logic                          pkt_tlast,
    input  logic                          pkt_tvalid,
    output logic                          pkt_tready,
    output logic [ID_WIDTH-1:0]           mem_awid,
    output logic [ADDR_WIDTH-1:0]         mem_awaddr,
    output logic [7:0]                    mem_awlen,
    output logic [2:0]                    mem_awsize,
    output logic [1:0]                    mem_awburst,
    output logic                          mem_awlock,
    output logic [3:0]                    mem_awcache,
    output logic [2:0]                    mem_awprot,
    output logic [3:0]                    mem_awqos,
    output logic [3:0]                    mem_awregion,
    output logic [AWUSER_WIDTH-1:0]       mem_awuser,
    output logic                          mem_awvalid,
    input  logic                          mem_awready,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [DATA_WIDTH_B-1:0]       mem_wstrb,
    output logic                          mem_wlast,
    output logic [WUSER_WIDTH-1:0]        mem_wuser,
    output logic                          mem_wvalid,
    input  logic                          mem_wready,
    input  logic [1:0]                    mem_bresp,
    input  logic                          mem_bvalid,
    output logic                          mem_bready,
    output logic [ID_WIDTH-1:0]           mem_arid,
    output logic [ADDR_WIDTH-1:0]         mem_araddr,
    output logic [7:0]                    mem_arlen,
    output logic [2:0]                    mem_arsize,
    output logic [1:0]                    mem_arburst,
    output logic                          mem_arlock,
    output logic [3:0]                    mem_arcache,
    output logic [2:0]                    mem_arprot,
    output logic [3:0]                    mem_arqos,
    output logic [3:0]                    mem_arregion,
    output logic [ARUSER_WIDTH-1:0]       mem_aruser,
    output logic                          mem_arvalid,
    output logic                          mem_rready
);

    localparam int ALIGN = $clog2(DATA_WIDTH_B);
    localparam int WW    = MAX_PKT_SIZE_WIDTH - ALIGN + 1;
    localparam int WL    = (WW > 9) ? WW : 9;
    localparam int CW    = MAX_PKT_SIZE_WIDTH + 1;
    localparam int PW    = ALIGN + 1;

    typedef enum logic [2:0] {
        IDLE_S,
        CALC_BURST_S,
        ADDR_S,
        DATA_S,
        PAD_S,
        RESP_S,
        DROP_S
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [WL-1:0]           words_left;
    logic [WL-1:0]           words_c;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH_B-1:0] last_mask;
    logic [DATA_WIDTH_B-1:0] mask_c;
    logic [ALIGN-1:0]        rem;
    logic [CW-1:0]           byte_cnt;
    logic [7:0]              beat_cnt;
    logic [PW-1:0]           pop;
    logic                    final_q;
    logic                    tlast_q;
    logic                    start;
    logic                    last_word;
    logic                    wlast_c;
    logic                    w_hs;
    logic                    done_set;

    assign rem       = pkt_size_i[ALIGN-1:0];
    assign start     = wr_stb_i && (pkt_size_i != '0);
    assign words_c   = WL'(pkt_size_i >> ALIGN) + WL'(rem != '0);
    assign last_word = (words_left == WL'(1));
    assign wlast_c   = (beat_cnt == mem_awlen);
    assign w_hs      = mem_wvalid && mem_wready;
    assign busy_o    = (state != IDLE_S);

    always_comb begin
        mask_c = '0;
        for (int i = 0; i < DATA_WIDTH_B; i++) begin
            mask_c[i] = (rem == '0) || (ALIGN'(i) < rem);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_WIDTH_B; i++) begin
            pop = pop + PW'(mem_wstrb[i]);
        end
    end

    assign mem_awid     = '0;
    assign mem_awsize   = 3'(ALIGN);
    assign mem_awburst  = 2'b01;
    assign mem_awlock   = 1'b0;
    assign mem_awcache  = '0;
    assign mem_awprot   = '0;
    assign mem_awqos    = '0;
    assign mem_awregion = '0;
    assign mem_awuser   = '0;
    assign mem_wuser    = '0;
    assign mem_arid     = '0;
    assign mem_araddr   = '0;
    assign mem_arlen    = '0;
    assign mem_arsize   = '0;
    assign mem_arburst  = '0;
    assign mem_arlock   = 1'b0;
    assign mem_arcache  = '0;
    assign mem_arprot   = '0;
    assign mem_arqos    = '0;
    assign mem_arregion = '0;
    assign mem_aruser   = '0;
    assign mem_arvalid  = 1'b0;
    assign mem_rready   = 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE_S;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pkt_tready = 1'b0;
        mem_wvalid = 1'b0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        mem_wlast  = 1'b0;
        mem_bready = 1'b0;
        done_set   = 1'b0;
        unique case (state)
            IDLE_S: begin
                if (start) state_nxt = CALC_BURST_S;
            end
            CALC_BURST_S: state_nxt = ADDR_S;
            ADDR_S: begin
                if (mem_awready) state_nxt = DATA_S;
            end
            DATA_S: begin
                pkt_tready = mem_wready;
                mem_wvalid = pkt_tvalid;
                mem_wdata  = pkt_tdata;
                mem_wstrb  = pkt_tkeep & (last_word ? last_mask : '1);
                mem_wlast  = wlast_c;
                if (pkt_tvalid && mem_wready) begin
                    if (wlast_c) state_nxt = RESP_S;
                    else if (pkt_tlast) state_nxt = PAD_S;
                end
            end
            PAD_S: begin
                mem_wvalid = 1'b1;
                mem_wlast  = wlast_c;
                if (mem_wready && wlast_c) state_nxt = RESP_S;
            end
            RESP_S: begin
                mem_bready = 1'b1;
                if (mem_bvalid) begin
                    if (!final_q) begin
                        state_nxt = CALC_BURST_S;
                    end else if (tlast_q) begin
                        state_nxt = IDLE_S;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = DROP_S;
                    end
                end
            end
            DROP_S: begin
                pkt_tready = 1'b1;
                if (pkt_tvalid && pkt_tlast) begin
                    state_nxt = IDLE_S;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            words_left  <= '0;
            cur_addr    <= '0;
            last_mask   <= '0;
            byte_cnt    <= '0;
            beat_cnt    <= '0;
            final_q     <= 1'b0;
            tlast_q     <= 1'b0;
            mem_awaddr  <= '0;
            mem_awlen   <= '0;
            mem_awvalid <= 1'b0;
            done_o      <= 1'b0;
            pkt_size_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            done_o <= done_set;
            if (done_set) pkt_size_o <= byte_cnt;
            unique case (state)
                IDLE_S: begin
                    if (start) begin
                        words_left <= words_c;
                        cur_addr   <= addr_i & ~ADDR_WIDTH'(DATA_WIDTH_B - 1);
                        last_mask  <= mask_c;
                        byte_cnt   <= '0;
                        err_o      <= 1'b0;
                    end
                end
                CALC_BURST_S: begin
                    mem_awaddr  <= cur_addr;
                    mem_awlen   <= (words_left > WL'(256)) ? 8'hff
                                 : 8'(words_left - WL'(1));
                    mem_awvalid <= 1'b1;
                    beat_cnt    <= '0;
                end
                ADDR_S: begin
                    if (mem_awready) mem_awvalid <= 1'b0;
                end
                DATA_S: begin
                    if (w_hs) begin
                        words_left <= words_left - WL'(1);
                        cur_addr   <= cur_addr + ADDR_WIDTH'(DATA_WIDTH_B);
                        beat_cnt   <= beat_cnt + 8'd1;
                        tlast_q    <= pkt_tlast;
                        // The closing beat counts only its enabled strobe bytes
                        if (pkt_tlast || last_word) begin
                            byte_cnt <= byte_cnt + CW'(pop);
                        end else begin
                            byte_cnt <= byte_cnt + CW'(DATA_WIDTH_B);
                        end
                        if (wlast_c) final_q <= pkt_tlast || last_word;
                    end
                end
                PAD_S: begin
                    final_q <= 1'b1;
                    if (w_hs) beat_cnt <= beat_cnt + 8'd1;
                end
                RESP_S: begin
                    if (mem_bvalid) err_o <= err_o | (mem_bresp != 2'b00);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// Bench for axi4_stream_to_axi4: table of packets, memory/stream models
// and scoreboard queues for AW, W and completion.
module tb_axi4_stream_to_axi4;

    localparam int DW  = 64;
    localparam int BW  = DW / 8;
    localparam int MPB = 4096;
    localparam int PW  = $clog2(MPB);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [PW-1:0]  pkt_size_i = '0;
    logic [31:0]    addr_i = '0;
    logic           wr_stb = 1'b0;
    logic           busy_o, done_o, err_o;
    logic [PW:0]    pkt_size_o;
    logic [DW-1:0]  tdata = '0;
    logic [BW-1:0]  tkeep = '0;
    logic           tlast = 1'b0, tvalid = 1'b0, tready;
    logic [0:0]     awid, awuser, wuser, arid, aruser;
    logic [31:0]    awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic [2:0]     awsize, awprot, arsize, arprot;
    logic [1:0]     awburst, arburst;
    logic           awlock, arlock;
    logic [3:0]     awcache, awqos, awregion, arcache, arqos, arregion;
    logic           awvalid, awready = 1'b0;
    logic [DW-1:0]  wdata;
    logic [BW-1:0]  wstrb;
    logic           wlast, wvalid, wready = 1'b0;
    logic [1:0]     bresp = 2'b00;
    logic           bvalid = 1'b0, bready;
    logic           arvalid, rready;

    always #5 clk = ~clk;

    axi4_stream_to_axi4 #(.MAX_PKT_SIZE_B(MPB)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pkt_size_i(pkt_size_i),
        .addr_i(addr_i), .wr_stb_i(wr_stb), .busy_o(busy_o),
        .done_o(done_o), .pkt_size_o(pkt_size_o), .err_o(err_o),
        .pkt_tdata(tdata), .pkt_tkeep(tkeep), .pkt_tlast(tlast),
        .pkt_tvalid(tvalid), .pkt_tready(tready),
        .mem_awid(awid), .mem_awaddr(awaddr), .mem_awlen(awlen),
        .mem_awsize(awsize), .mem_awburst(awburst),
        .mem_awlock(awlock), .mem_awcache(awcache),
        .mem_awprot(awprot), .mem_awqos(awqos),
        .mem_awregion(awregion), .mem_awuser(awuser),
        .mem_awvalid(awvalid), .mem_awready(awready),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_wlast(wlast),
        .mem_wuser(wuser), .mem_wvalid(wvalid), .mem_wready(wready),
        .mem_bresp(bresp), .mem_bvalid(bvalid), .mem_bready(bready),
        .mem_arid(arid), .mem_araddr(araddr), .mem_arlen(arlen),
        .mem_arsize(arsize), .mem_arburst(arburst),
        .mem_arlock(arlock), .mem_arcache(arcache),
        .mem_arprot(arprot), .mem_arqos(arqos),
        .mem_arregion(arregion), .mem_aruser(aruser),
        .mem_arvalid(arvalid), .mem_rready(rready)
    );

    typedef struct {
        int size; logic [31:0] addr; int beats; int aw_delay;
        bit rnd; bit bad; int exp_size; bit exp_err;
    } vec_t;
    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; logic last; logic pad; } w_t;
    typedef struct { int size; logic err; } done_t;

    beat_t src_q[$];
    aw_t   aw_q[$];
    w_t    w_q[$];
    done_t done_q[$];
    vec_t  tbl[8];

    int total = 0, bad = 0;
    int aw_delay = 0, aw_cnt = 0, burst_no = 0;
    int w_cnt = 0, done_cnt = 0;
    bit rnd = 0, bad_first = 0;
    bit t_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    bit burst_open = 0, b_pending = 0, aw_hold = 0;
    logic [31:0] hold_addr = '0;
    logic [7:0]  hold_len = '0;
    bit stb_pend = 0;
    logic [PW-1:0] pend_size = '0;
    logic [31:0]   pend_addr = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        total++;
        bad++;
        $display("FAIL %s: got unexpected event want none", name);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic build(input vec_t v);
        int w, rem, nw, lastb, nend, base, k, blen;
        logic [7:0] mask;
        w = (v.size + BW - 1) / BW;
        rem = v.size % BW;
        mask = (rem == 0) ? 8'hff : 8'((1 << rem) - 1);
        base = src_q.size();
        for (int i = 0; i < v.beats; i++)
            src_q.push_back('{{$urandom, $urandom}, 8'hff, (i == v.beats - 1)});
        nw = imin(v.beats, w);
        lastb = (nw - 1) / 256;
        for (int b = 0; b <= lastb; b++)
            aw_q.push_back('{(v.addr & ~32'h7) + 32'(b * 2048),
                             8'(imin(w - 256 * b, 256) - 1)});
        nend = lastb * 256 + imin(w - 256 * lastb, 256);
        for (int i = 0; i < nend; i++) begin
            k = i / 256;
            blen = imin(w - 256 * k, 256);
            if (i < nw)
                w_q.push_back('{src_q[base + i].data,
                                (i == w - 1) ? mask : 8'hff,
                                ((i % 256) == blen - 1), 1'b0});
            else
                w_q.push_back('{64'h0, 8'h00, ((i % 256) == blen - 1), 1'b1});
        end
        done_q.push_back('{v.exp_size, v.exp_err});
    endtask

    task automatic drive();
        wr_stb = stb_pend;
        if (stb_pend) begin
            pkt_size_i = pend_size;
            addr_i = pend_addr;
        end
        stb_pend = 0;
        if (!rst_n) begin
            src_q.delete(); aw_q.delete(); w_q.delete(); done_q.delete();
            tvalid = 0; awready = 0; wready = 0; bvalid = 0;
            t_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            burst_open = 0; b_pending = 0; aw_hold = 0; aw_cnt = 0;
            return;
        end
        if (t_hs && src_q.size() > 0) src_q.delete(0);
        if (src_q.size() == 0) begin
            tvalid = 0;
        end else begin
            if (!tvalid || t_hs)
                tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tdata = src_q[0].data;
            tkeep = src_q[0].keep;
            tlast = src_q[0].last;
        end
        if (awvalid) aw_cnt++;
        else aw_cnt = 0;
        awready = awvalid && (aw_cnt > aw_delay);
        wready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (b_hs) bvalid = 0;
        if (b_pending && !bvalid) begin
            bvalid = 1;
            bresp = (bad_first && burst_no == 0) ? 2'b10 : 2'b00;
            burst_no++;
            b_pending = 0;
        end
    endtask

    task automatic sample();
        aw_t ea;
        w_t ew;
        done_t ed;
        if (!rst_n) return;
        t_hs = tvalid && tready;
        aw_hs = awvalid && awready;
        w_hs = wvalid && wready;
        b_hs = bvalid && bready;
        if (aw_hold) begin
            chk("aw_hold_valid", awvalid, 1);
            chk("aw_hold_addr", awaddr, hold_addr);
            chk("aw_hold_len", awlen, hold_len);
        end
        if (wvalid) chk("w_after_aw", burst_open, 1);
        if (aw_hs) begin
            chk("aw_single", burst_open, 0);
            if (aw_q.size() == 0) miss("aw_extra");
            else begin
                ea = aw_q.pop_front();
                chk("awaddr", awaddr, ea.addr);
                chk("awlen", awlen, ea.len);
                chk("awsize", awsize, 3);
                chk("awburst", awburst, 1);
            end
            burst_open = 1;
        end
        if (w_hs) begin
            if (w_q.size() == 0) miss("w_extra");
            else begin
                ew = w_q.pop_front();
                chk("wdata", wdata, ew.data);
                chk("wstrb", wstrb, ew.strb);
                chk("wlast", wlast, ew.last);
                if (ew.pad) chk("pad_tready", tready, 0);
            end
            w_cnt++;
            if (wlast) b_pending = 1;
        end
        if (b_hs) burst_open = 0;
        if (done_o) begin
            if (done_q.size() == 0) miss("done_extra");
            else begin
                ed = done_q.pop_front();
                chk("pkt_size_o", pkt_size_o, ed.size);
                chk("err_o_at_done", err_o, ed.err);
            end
            done_cnt++;
        end
        aw_hold = awvalid && !awready;
        hold_addr = awaddr;
        hold_len = awlen;
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #4;
        sample();
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_busy"}, busy_o, 0);
        chk({p, "_done"}, done_o, 0);
        chk({p, "_awvalid"}, awvalid, 0);
        chk({p, "_wvalid"}, wvalid, 0);
        chk({p, "_bready"}, bready, 0);
        chk({p, "_tready"}, tready, 0);
        chk({p, "_err"}, err_o, 0);
        chk({p, "_pkt_size"}, pkt_size_o, 0);
        chk({p, "_awaddr"}, awaddr, 0);
        chk({p, "_awlen"}, awlen, 0);
        chk({p, "_arvalid"}, arvalid, 0);
        chk({p, "_rready"}, rready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk_idle("rst_async");
        repeat (2) tick();
        @(negedge clk);
        #2 rst_n = 1;
    endtask

    task automatic run(input vec_t v);
        int s;
        aw_delay = v.aw_delay;
        rnd = v.rnd;
        bad_first = v.bad;
        burst_no = 0;
        build(v);
        stb_pend = 1;
        pend_size = PW'(v.size);
        pend_addr = v.addr;
        s = done_cnt;
        tick();
        tick();
        chk("busy_after_stb", busy_o, 1);
        for (int c = 0; c < 6000 && done_cnt == s; c++) begin
            if (c == 3) begin
                stb_pend = 1;
                pend_size = PW'(8);
                pend_addr = 32'h9000;
            end
            tick();
        end
        if (done_cnt == s) begin
            miss("done_timeout");
            do_reset();
        end
        repeat (3) tick();
        chk("aw_left", aw_q.size(), 0);
        chk("w_left", w_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("src_left", src_q.size(), 0);
        chk("busy_idle", busy_o, 0);
        chk("err_sticky", err_o, v.exp_err);
    endtask

    initial begin
        int s;
        tbl[0] = '{64,   32'h1003, 8,   0, 1'b0, 1'b0, 64,   1'b0};
        tbl[1] = '{4000, 32'h0000, 500, 0, 1'b1, 1'b0, 4000, 1'b0};
        tbl[2] = '{20,   32'h2000, 3,   0, 1'b0, 1'b0, 20,   1'b0};
        tbl[3] = '{64,   32'h3000, 3,   0, 1'b0, 1'b0, 24,   1'b0};
        tbl[4] = '{16,   32'h4000, 4,   0, 1'b0, 1'b0, 16,   1'b0};
        tbl[5] = '{100,  32'h5008, 13,  5, 1'b1, 1'b1, 100,  1'b1};
        tbl[6] = '{72,   32'h6004, 9,   2, 1'b1, 1'b0, 72,   1'b0};
        tbl[7] = '{24,   32'h7000, 5,   1, 1'b1, 1'b0, 24,   1'b0};

        repeat (3) tick();
        @(negedge clk);
        #2 rst_n = 1;
        tick();
        chk_idle("reset");

        for (int i = 0; i < 8; i++) begin
            run(tbl[i]);
            if (i == 5) begin
                stb_pend = 1;
                pend_size = '0;
                pend_addr = 32'h8000;
                s = done_cnt;
                repeat (6) tick();
                chk("zero_busy", busy_o, 0);
                chk("zero_awvalid", awvalid, 0);
                chk("zero_done", done_cnt - s, 0);
                chk("zero_err_kept", err_o, 1);
            end
        end

        aw_delay = 0;
        rnd = 0;
        bad_first = 0;
        burst_no = 0;
        build(tbl[0]);
        stb_pend = 1;
        pend_size = PW'(64);
        pend_addr = 32'h1003;
        s = w_cnt;
        for (int c = 0; c < 200 && (w_cnt - s) < 3; c++) tick();
        chk("mid_beats", (w_cnt - s) >= 3, 1);
        chk("mid_wvalid", wvalid, 1);
        do_reset();
        tick();
        chk_idle("after_rst");
        run(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_stream_to_axi4.md
# axi4_stream_to_axi4

Write-side DMA stage of the frame buffer: accepts one AXI4-Stream packet per write strobe and stores it to memory through AXI4 INCR write bursts of at most 256 beats. It sits directly upstream of the memory in the write path, and its memory image is what the read-side stream converter later fetches. Packet length is supplied up front. Early `tlast` pads the open burst; excess stream data is dropped.

## Interface
- DATA_WIDTH, 64, bus width of stream and memory data (bits); DATA_WIDTH_B = DATA_WIDTH/8
- ADDR_WIDTH, 32, AXI address width
- ID_WIDTH / AWUSER_WIDTH / WUSER_WIDTH / ARUSER_WIDTH / TUSER_WIDTH / TDEST_WIDTH, 1, sideband widths
- MAX_PKT_SIZE_B, 2048, maximum packet size in bytes
- MAX_PKT_SIZE_WIDTH, $clog2(MAX_PKT_SIZE_B), width of the byte-size fields
- clk_i  in  1  single clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- pkt_size_i  in  MAX_PKT_SIZE_WIDTH  expected packet size in bytes, sampled with wr_stb_i
- addr_i  in  ADDR_WIDTH  base address, sampled with wr_stb_i, low log2(DATA_WIDTH_B) bits forced to 0
- wr_stb_i  in  1  start request, honoured only in IDLE_S
- busy_o  out  1  high in every state except IDLE_S
- done_o  out  1  one-cycle pulse when the packet is finished
- pkt_size_o  out  MAX_PKT_SIZE_WIDTH+1  bytes actually written, valid from done_o until the next done_o
- err_o  out  1  sticky: set on any bresp != 2'b00, cleared on accepted wr_stb_i
- pkt_i  axi4_stream_if.slave  incoming packet
- mem_o  axi4_if.master  memory; read channels tied off (arvalid=0, rready=1)

## Operation
- Word count: words = pkt_size_i / DATA_WIDTH_B, plus 1 if the remainder is nonzero. last_mask = all ones if the remainder is 0, otherwise the low `remainder` bits set.
- wr_stb_i with pkt_size_i == 0 is ignored. busy_o stays 0 and done_o does not pulse.
- States:
  - IDLE_S: on wr_stb_i, latch the word count, the aligned address and last_mask; clear the byte counter and err_o; go to CALC_BURST_S.
  - CALC_BURST_S: register awaddr = cur_addr and awlen = min(words_left, 256) - 1; go to ADDR_S.
  - ADDR_S: awvalid = 1 until the awready handshake, then DATA_S.
  - DATA_S: wvalid = pkt_i.tvalid, pkt_i.tready = wready, wdata = tdata.
    - wstrb = tkeep, additionally ANDed with last_mask on packet word words-1.
    - wlast is asserted on beat awlen.
    - Each W handshake decrements words_left and advances cur_addr by DATA_WIDTH_B.
  - End of a burst in DATA_S, on the wlast handshake:
    - tlast on that beat, or words_left reaches 0: go to RESP_S, final.
    - otherwise: go to RESP_S, non-final.
  - tlast before the burst end in DATA_S: go to PAD_S.
  - PAD_S: tready = 0; drive wvalid = 1, wstrb = 0, wdata = 0 until the wlast handshake, then go to RESP_S, final.
  - RESP_S: bready = 1. On the bvalid handshake, OR (bresp != 0) into err_o.
    - final: if the last accepted word lacked tlast, go to DROP_S.
    - final, otherwise: go to IDLE_S and pulse done_o.
    - non-final: go to CALC_BURST_S.
  - DROP_S: tready = 1, nothing written. On the tlast handshake, go to IDLE_S and pulse done_o.
- Byte counter:
  - adds DATA_WIDTH_B for each written beat that is neither a tlast beat nor the final packet word;
  - adds popcount(wstrb) on the final written beat;
  - pad beats add 0.
  - pkt_size_o registers the counter when done_o pulses.
- Bursts are never split at 4 KB boundaries; the frame buffer layout guarantees alignment.
- Constant AW fields: awsize = log2(DATA_WIDTH_B), awburst = 2'b01, awid/awlock/awcache/awprot/awqos/awregion/awuser/wuser = 0.

## Timing
- Reset values: state IDLE_S, awvalid 0, wvalid 0, bready 0, pkt_i.tready 0, done_o 0, busy_o 0, err_o 0, pkt_size_o 0, awaddr 0, awlen 0.
- Latency: wr_stb_i at cycle N → CALC_BURST_S at N+1 → awvalid high at N+2. First W beat is possible at the cycle after the AW handshake.
- W is never driven before its AW handshake. The next AW is never issued before the previous B handshake, so one burst is outstanding at a time.
- awvalid, awaddr and awlen are stable until awready. wvalid/wdata in DATA_S follow the stream combinationally.
- err_o and pkt_size_o are valid in the same cycle as done_o.
- wr_stb_i while busy_o = 1 is ignored.
- rst_n_i low mid-burst returns all outputs to reset values immediately. The partial burst is abandoned; the interconnect must be reset with it.

## Test plan
- pkt_size_i=64, addr_i=0x1003, 8 beats with tlast on beat 8 → one AW: awaddr 0x1000, awlen 7. 8 W beats, wstrb 0xFF, wlast on beat 8. done_o pulses with pkt_size_o=64.
- MAX_PKT_SIZE_B=4096, pkt_size_i=4000, addr_i=0 → bursts awlen 255 at 0x0 and awlen 243 at 0x800. Each AW follows the previous B. pkt_size_o=4000.
- pkt_size_i=20, tkeep 0xFF on all beats, tlast on beat 3 → wstrb 0xFF, 0xFF, 0x0F; pkt_size_o=20.
- pkt_size_i=64, tlast on beat 3 → 5 pad beats with wstrb 0, tready 0 during pad; pkt_size_o=24.
- pkt_size_i=16, 4-beat stream → 2 beats written (awlen 1), beats 3–4 dropped with tready 1; done_o after tlast; pkt_size_o=16.
- awready delayed 5 cycles, random wready/tvalid, bresp=2'b10 on the first burst → no data loss, err_o=1 at done_o. Assert rst_n_i mid-burst → all outputs return to reset values the same cycle.
